pc_ctrl_unit: RTL and testbench

Parametrised program-counter controller for the single-cycle MIPS core; supersedes the plain run/clear PC counter. Computes next PC (sequential, branch, jump), supports stall, a monitor-set hardware breakpoint, a configurable PC-overflow watchdog and a retired-instruction counter. Sits between sys_monitor (run/clear/breakpoint controls), the controller (branch/jump) and the instruction ROM address.

---
 rtl/pc_ctrl_unit.sv | 190 +++++++++++++++++++
 tb/tb_pc_ctrl_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl_unit.sv
// Program-counter controller for the single-cycle MIPS core.
// Computes the next PC (sequential / beq branch / jump) and gates PC advance with a small
// run-control FSM: IDLE, RUN, BREAK (hardware breakpoint) and OVF (PC-overflow watchdog).
// Also counts retired instructions (PC advances).
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   run_en_i, clr_i     monitor run enable and synchronous PC clear
//   stall_i             hold PC this cycle
//   branch_i, zero_i    beq and ALU zero; pcsrc_o = branch_i & zero_i
//   jump_i, instr_i     jump and instr[25:0] (imm = instr_i[15:0])
//   bp_set_i, bp_idx_i  load breakpoint word index and arm it
//   bp_clr_i            disarm breakpoint (beats bp_set_i)
//   resume_i            leave BREAK (needs run_en_i)
//   pc_o, pc_plus4_o    current PC and PC + 4
//   state_o             00 IDLE, 01 RUN, 10 BREAK, 11 OVF
//   pc_ov_o, bp_hit_o   sticky overflow flag, one-cycle breakpoint-entry pulse
//   retired_o           count of PC advances
module pc_ctrl_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     INST_NUM = 18,
  parameter int unsigned     IDX_W    = 6,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en_i,
  input  logic             clr_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             zero_i,
  input  logic             jump_i,
  input  logic [25:0]      instr_i,
  input  logic             bp_set_i,
  input  logic [IDX_W-1:0] bp_idx_i,
  input  logic             bp_clr_i,
  input  logic             resume_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pc_plus4_o,
  output logic             pcsrc_o,
  output logic [1:0]       state_o,
  output logic             pc_ov_o,
  output logic             bp_hit_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StBreak = 2'b10,
    StOvf   = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               ov_q, ov_d;
  logic               armed_q, armed_d;
  logic [IDX_W-1:0]   bp_idx_q, bp_idx_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [PC_W-1:0]    pc_plus4;
  logic [PC_W-1:0]    jump_target;
  logic [PC_W-1:0]    branch_off;
  logic [PC_W-1:0]    next_pc;
  logic [27:0]        jump_low;
  logic [31:0]        off32;
  logic [IDX_W-1:0]   word_idx;
  logic               ovf_match;
  logic               bp_match;

  assign pc_plus4 = pc_q + PC_W'(4);
  assign jump_low = {instr_i, 2'b00};
  assign off32    = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

  // Narrow PCs simply truncate the 28-bit jump field and the branch offset.
  if (PC_W > 28) begin : g_jump_wide
    assign jump_target = {pc_plus4[PC_W-1:28], jump_low};
  end else begin : g_jump_narrow
    assign jump_target = jump_low[PC_W-1:0];
  end

  if (PC_W > 32) begin : g_off_wide
    assign branch_off = {{(PC_W-32){off32[31]}}, off32};
  end else begin : g_off_narrow
    assign branch_off = off32[PC_W-1:0];
  end

  assign pcsrc_o = branch_i & zero_i;

  always_comb begin
    next_pc = pc_plus4;
    if (jump_i) begin
      next_pc = jump_target;
    end else if (pcsrc_o) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  assign word_idx  = pc_q[IDX_W+1:2];
  assign ovf_match = (word_idx == IDX_W'(INST_NUM));
  assign bp_match  = armed_q && (word_idx == bp_idx_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ov_d      = ov_q;
    armed_d   = armed_q;
    bp_idx_d  = bp_idx_q;
    hit_d     = 1'b0;
    retired_d = retired_q;

    if (bp_set_i) begin
      bp_idx_d = bp_idx_i;
      armed_d  = 1'b1;
    end
    if (bp_clr_i) begin
      armed_d = 1'b0;
    end

    if (clr_i) begin
      state_d   = StIdle;
      pc_d      = RESET_PC;
      ov_d      = 1'b0;
      retired_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run_en_i) state_d = StRun;
        end
        StRun: begin
          // Watchdog outranks the breakpoint; both are checked before any advance.
          if (ovf_match) begin
            state_d = StOvf;
            ov_d    = 1'b1;
          end else if (bp_match) begin
            state_d = StBreak;
            hit_d   = 1'b1;
          end else if (!run_en_i) begin
            state_d = StIdle;
          end else if (!stall_i) begin
            pc_d      = next_pc;
            retired_d = retired_q + CNT_W'(1);
          end
        end
        StBreak: begin
          // Advancing on resume moves off the breakpoint PC so it is not re-hit.
          if (resume_i && run_en_i) begin
            state_d   = StRun;
            pc_d      = next_pc;
            retired_d = retired_q + CNT_W'(1);
          end
        end
        StOvf: begin
          state_d = StOvf;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ov_q      <= 1'b0;
      armed_q   <= 1'b0;
      bp_idx_q  <= '0;
      hit_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ov_q      <= ov_d;
      armed_q   <= armed_d;
      bp_idx_q  <= bp_idx_d;
      hit_q     <= hit_d;
      retired_q <= retired_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;
  assign state_o    = state_q;
  assign pc_ov_o    = ov_q;
  assign bp_hit_o   = hit_q;
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Self-checking bench for pc_ctrl_unit (default parameters): directed scenarios followed by
// randomized stimulus, every cycle compared against a behavioural model of the PC controller.
module tb_pc_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst, run_en, clr, stall, branch, zero, jump;
  logic [25:0] instr;
  logic        bp_set, bp_clr, resume;
  logic [5:0]  bp_idx;
  logic [31:0] pc_o, pc_plus4_o, retired_o;
  logic        pcsrc_o, pc_ov_o, bp_hit_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 run, 2 break, 3 overflow.
  int unsigned m_pc, m_ret, m_idx;
  int          m_st;
  bit          m_ov, m_armed, m_hit;

  pc_ctrl_unit dut (
    .clk        (clk),
    .rst        (rst),
    .run_en_i   (run_en),
    .clr_i      (clr),
    .stall_i    (stall),
    .branch_i   (branch),
    .zero_i     (zero),
    .jump_i     (jump),
    .instr_i    (instr),
    .bp_set_i   (bp_set),
    .bp_idx_i   (bp_idx),
    .bp_clr_i   (bp_clr),
    .resume_i   (resume),
    .pc_o       (pc_o),
    .pc_plus4_o (pc_plus4_o),
    .pcsrc_o    (pcsrc_o),
    .state_o    (state_o),
    .pc_ov_o    (pc_ov_o),
    .bp_hit_o   (bp_hit_o),
    .retired_o  (retired_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned target_pc();
    int unsigned p4 = m_pc + 4;
    int          off;
    if (jump) return (p4 & 32'hF000_0000) | (32'(instr) * 4);
    if (branch && zero) begin
      off = int'($signed(instr[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // One clock: predict from current inputs, clock the DUT, then compare everything.
  task automatic cycle();
    int unsigned n_pc = m_pc, n_ret = m_ret, n_idx = m_idx, widx;
    int          n_st = m_st;
    bit          n_ov = m_ov, n_armed = m_armed, n_hit = 1'b0;
    widx = (m_pc / 4) % 64;
    if (rst) begin
      n_pc = 0; n_ret = 0; n_idx = 0; n_st = 0; n_ov = 0; n_armed = 0;
    end else begin
      if (bp_set) begin n_idx = bp_idx; n_armed = 1; end
      if (bp_clr) n_armed = 0;
      if (clr) begin
        n_pc = 0; n_ov = 0; n_ret = 0; n_st = 0;
      end else if (m_st == 0) begin
        if (run_en) n_st = 1;
      end else if (m_st == 1) begin
        if (widx == 18) begin n_st = 3; n_ov = 1; end
        else if (m_armed && widx == m_idx) begin n_st = 2; n_hit = 1; end
        else if (!run_en) n_st = 0;
        else if (!stall) begin n_pc = target_pc(); n_ret = m_ret + 1; end
      end else if (m_st == 2) begin
        if (resume && run_en) begin n_st = 1; n_pc = target_pc(); n_ret = m_ret + 1; end
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ret = n_ret; m_idx = n_idx; m_st = n_st;
    m_ov = n_ov; m_armed = n_armed; m_hit = n_hit;
    chk("pc", pc_o, m_pc);
    chk("pc_plus4", pc_plus4_o, m_pc + 4);
    chk("pcsrc", 32'(pcsrc_o), 32'(branch & zero));
    chk("state", 32'(state_o), 32'(m_st));
    chk("pc_ov", 32'(pc_ov_o), 32'(m_ov));
    chk("bp_hit", 32'(bp_hit_o), 32'(m_hit));
    chk("retired", retired_o, m_ret);
  endtask

  initial begin
    int hits;
    int n;
    rst = 1; run_en = 0; clr = 0; stall = 0; branch = 0; zero = 0; jump = 0;
    instr = '0; bp_set = 0; bp_idx = '0; bp_clr = 0; resume = 0;
    m_pc = 0; m_ret = 0; m_idx = 0; m_st = 0; m_ov = 0; m_armed = 0; m_hit = 0;
    cycle(); cycle();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ret", retired_o, 32'd0);

    // Sequential run: first edge leaves IDLE, next five advance.
    rst = 0; run_en = 1;
    repeat (6) cycle();
    chk("seq_pc", pc_o, 32'd20);
    chk("seq_ret", retired_o, 32'd5);
    chk("seq_state", 32'(state_o), 32'd1);

    // Branch / jump.
    rst = 1; cycle(); rst = 0;
    repeat (5) cycle();
    chk("br_start", pc_o, 32'h10);
    branch = 1; zero = 1; instr = 26'h000FFFE;
    cycle();
    chk("br_taken", pc_o, 32'h0C);
    zero = 0;
    cycle();
    chk("br_not_taken", pc_o, 32'h10);
    jump = 1; zero = 1; instr = 26'h0000008;
    cycle();
    chk("jump_over_branch", pc_o, 32'h20);
    branch = 0; zero = 0; jump = 0; instr = '0;

    // Breakpoint at word 3.
    rst = 1; run_en = 0; cycle(); rst = 0;
    bp_set = 1; bp_idx = 6'd3; cycle(); bp_set = 0;
    run_en = 1; hits = 0;
    repeat (8) begin cycle(); hits += int'(bp_hit_o); end
    chk("bp_pc", pc_o, 32'h0C);
    chk("bp_state", 32'(state_o), 32'd2);
    chk("bp_hits", 32'(hits), 32'd1);
    resume = 1; cycle(); resume = 0;
    chk("resume_pc", pc_o, 32'h10);
    chk("resume_state", 32'(state_o), 32'd1);

    // Overflow watchdog at word 18.
    n = 0;
    while (pc_o != 32'h48 && n < 40) begin cycle(); n++; end
    cycle();
    chk("ovf_state", 32'(state_o), 32'd3);
    chk("ovf_flag", 32'(pc_ov_o), 32'd1);
    repeat (10) cycle();
    chk("ovf_frozen", pc_o, 32'h48);
    clr = 1; cycle(); clr = 0;
    chk("clr_pc", pc_o, 32'h0);
    chk("clr_ov", 32'(pc_ov_o), 32'd0);
    chk("clr_state", 32'(state_o), 32'd0);

    // Stall and run-enable drop.
    bp_clr = 1; cycle(); bp_clr = 0;
    repeat (2) cycle();
    chk("stall_start", pc_o, 32'h8);
    stall = 1; repeat (3) cycle(); stall = 0;
    chk("stall_pc", pc_o, 32'h8);
    chk("stall_ret", retired_o, 32'd2);
    run_en = 0; cycle(); cycle();
    chk("idle_state", 32'(state_o), 32'd0);
    chk("idle_pc", pc_o, 32'h8);

    // Reset while in BREAK clears the breakpoint.
    bp_set = 1; bp_idx = 6'd3; cycle(); bp_set = 0;
    run_en = 1; repeat (6) cycle();
    chk("brk_again", 32'(state_o), 32'd2);
    rst = 1; cycle(); rst = 0;
    chk("rst_brk_pc", pc_o, 32'h0);
    chk("rst_brk_ret", retired_o, 32'd0);
    repeat (7) cycle();
    chk("rerun_state", 32'(state_o), 32'd1);
    chk("rerun_pc", pc_o, 32'h18);

    // Randomized traffic.
    repeat (400) begin
      rst    = ($urandom_range(0, 99) == 0);
      clr    = ($urandom_range(0, 49) == 0);
      run_en = ($urandom_range(0, 9) != 0);
      stall  = ($urandom_range(0, 4) == 0);
      branch = 1'($urandom);
      zero   = 1'($urandom);
      jump   = ($urandom_range(0, 9) == 0);
      instr  = 26'($urandom);
      bp_set = ($urandom_range(0, 9) == 0);
      bp_idx = 6'($urandom);
      bp_clr = ($urandom_range(0, 19) == 0);
      resume = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
